// File: rtl/activation_line_buffer_controller.sv
// Activation line buffer sequencer: packs input beats across banks of a row,
// and manages the rows as a circular FIFO toward the compute stream reader.
module activation_line_buffer_controller #(
    parameter int ACTIVATION_BANK_BIT_WIDTH    = 64,
    parameter int ACTIVATION_LINE_BUFFER_DEPTH = 4,
    parameter int ACTIVATION_BUFFER_BANK_COUNT = 4,
    localparam int AW = $clog2(ACTIVATION_LINE_BUFFER_DEPTH)
) (
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic                                    i_clear,
    input  logic [ACTIVATION_BANK_BIT_WIDTH-1:0]    i_data,
    input  logic                                    i_data_valid,
    output logic                                    o_data_ready,
    output logic [ACTIVATION_BANK_BIT_WIDTH-1:0]    o_activation_buffer_data_in,
    output logic                                    o_activation_buffer_write_port_en,
    output logic [ACTIVATION_BUFFER_BANK_COUNT-1:0] o_activation_buffer_write_enable,
    output logic [AW-1:0]                           o_activation_buffer_address_in_bus,
    output logic [AW-1:0]                           o_activation_buffer_address_in_compute,
    input  logic                                    i_row_read_req,
    output logic                                    o_row_read_ack,
    output logic                                    o_row_data_valid,
    output logic [AW:0]                             o_rows_available,
    output logic                                    o_full,
    output logic                                    o_empty
);

    localparam int BC = ACTIVATION_BUFFER_BANK_COUNT;
    localparam int BW = $clog2(BC);

    localparam logic [AW:0]    DEPTH_PTR     = (AW+1)'(ACTIVATION_LINE_BUFFER_DEPTH);
    localparam logic [AW:0]    PTR_ONE       = (AW+1)'(1);
    localparam logic [BW-1:0]  BANK_ONE      = BW'(1);
    localparam logic [BW-1:0]  LAST_BANK     = BW'(BC - 1);
    localparam logic [BC-1:0]  BANK0_ONEHOT  = BC'(1);

    logic [BW-1:0] bank_idx;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   commit_ptr;
    logic [AW:0]   rd_ptr;

    logic                                 wr_port_en_q;
    logic [BC-1:0]                        wr_en_q;
    logic [ACTIVATION_BANK_BIT_WIDTH-1:0] wr_data_q;
    logic [AW-1:0]                        wr_addr_q;
    logic                                 row_valid_q;

    logic accept;
    logic ack;

    // The extra pointer MSB separates a completely full buffer from an empty one.
    assign o_data_ready = (wr_ptr - rd_ptr) != DEPTH_PTR;
    assign accept       = i_data_valid && o_data_ready && !i_clear;
    assign ack          = i_row_read_req && (commit_ptr != rd_ptr) && !i_clear;

    assign o_row_read_ack                         = ack;
    assign o_activation_buffer_address_in_compute = rd_ptr[AW-1:0];
    assign o_rows_available                       = commit_ptr - rd_ptr;
    assign o_empty                                = commit_ptr == rd_ptr;
    assign o_full                                 = !o_data_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bank_idx   <= '0;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
        end else if (i_clear) begin
            bank_idx   <= '0;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
        end else begin
            // Lagging wr_ptr by one cycle publishes a row only after its last bank write issues.
            commit_ptr <= wr_ptr;
            if (accept) begin
                if (bank_idx == LAST_BANK) begin
                    bank_idx <= '0;
                    wr_ptr   <= wr_ptr + PTR_ONE;
                end else begin
                    bank_idx <= bank_idx + BANK_ONE;
                end
            end
            if (ack) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_port_en_q <= 1'b0;
            wr_en_q      <= '0;
            wr_data_q    <= '0;
            wr_addr_q    <= '0;
            row_valid_q  <= 1'b0;
        end else if (i_clear) begin
            wr_port_en_q <= 1'b0;
            wr_en_q      <= '0;
            wr_data_q    <= '0;
            wr_addr_q    <= '0;
            row_valid_q  <= 1'b0;
        end else begin
            wr_port_en_q <= accept;
            row_valid_q  <= ack;
            if (accept) begin
                wr_en_q   <= BANK0_ONEHOT << bank_idx;
                wr_data_q <= i_data;
                wr_addr_q <= wr_ptr[AW-1:0];
            end else begin
                wr_en_q <= '0;
            end
        end
    end

    // A write registered just before a clear must not reach the BRAM.
    assign o_activation_buffer_write_port_en  = wr_port_en_q && !i_clear;
    assign o_activation_buffer_write_enable   = wr_en_q & {BC{!i_clear}};
    assign o_activation_buffer_data_in        = wr_data_q;
    assign o_activation_buffer_address_in_bus = wr_addr_q;
    assign o_row_data_valid                   = row_valid_q;

endmodule

// File: tb/tb_activation_line_buffer_controller.sv
// Directed bench for activation_line_buffer_controller with a small BRAM model
// behind the write/read ports to confirm row data order.
module tb_activation_line_buffer_controller;

    localparam int W  = 64;
    localparam int D  = 4;
    localparam int BC = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          resetn;
    logic          clr;
    logic [W-1:0]  din;
    logic          dv;
    logic          rdy;
    logic [W-1:0]  bdata;
    logic          wpe;
    logic [BC-1:0] wen;
    logic [AW-1:0] abus;
    logic [AW-1:0] acomp;
    logic          rreq;
    logic          ack;
    logic          rvalid;
    logic [AW:0]   ravail;
    logic          full;
    logic          empty;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    activation_line_buffer_controller #(
        .ACTIVATION_BANK_BIT_WIDTH   (W),
        .ACTIVATION_LINE_BUFFER_DEPTH(D),
        .ACTIVATION_BUFFER_BANK_COUNT(BC)
    ) dut (
        .clk                                   (clk),
        .resetn                                (resetn),
        .i_clear                               (clr),
        .i_data                                (din),
        .i_data_valid                          (dv),
        .o_data_ready                          (rdy),
        .o_activation_buffer_data_in           (bdata),
        .o_activation_buffer_write_port_en     (wpe),
        .o_activation_buffer_write_enable      (wen),
        .o_activation_buffer_address_in_bus    (abus),
        .o_activation_buffer_address_in_compute(acomp),
        .i_row_read_req                        (rreq),
        .o_row_read_ack                        (ack),
        .o_row_data_valid                      (rvalid),
        .o_rows_available                      (ravail),
        .o_full                                (full),
        .o_empty                               (empty)
    );

    // Simple dual-port BRAM with byte-column-free bank enables and registered read.
    logic [W-1:0] mem  [0:D-1][0:BC-1];
    logic [W-1:0] dout [0:BC-1];

    always @(posedge clk) begin
        for (int k = 0; k < BC; k++) begin
            if (wpe && wen[k]) mem[abus][k] <= bdata;
            dout[k] <= mem[acomp][k];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear;
        clr  = 1'b1;
        dv   = 1'b0;
        rreq = 1'b0;
        tick;
        clr  = 1'b0;
    endtask

    // Four beats into row 0, then one row read.
    task automatic run_basic(input string tg);
        dv  = 1'b1;
        din = 64'hA0;
        tick;
        for (int k = 0; k < 4; k++) begin
            chk({tg, "_wpe"},  64'(wpe),   64'd1);
            chk({tg, "_wen"},  64'(wen),   64'(1) << k);
            chk({tg, "_data"}, bdata,      64'(64'hA0 + k));
            chk({tg, "_abus"}, 64'(abus),  64'd0);
            if (k == 3) begin
                chk({tg, "_avail_before_commit"}, 64'(ravail), 64'd0);
                dv = 1'b0;
            end else begin
                din = 64'(64'hA1 + k);
            end
            tick;
        end
        chk({tg, "_wpe_idle"}, 64'(wpe),    64'd0);
        chk({tg, "_avail"},    64'(ravail), 64'd1);
        chk({tg, "_nonempty"}, 64'(empty),  64'd0);
        rreq = 1'b1;
        #1;
        chk({tg, "_ack"},   64'(ack),   64'd1);
        chk({tg, "_acomp"}, 64'(acomp), 64'd0);
        tick;
        rreq = 1'b0;
        chk({tg, "_rvalid"},   64'(rvalid), 64'd1);
        chk({tg, "_dout0"},    dout[0],     64'hA0);
        chk({tg, "_dout3"},    dout[3],     64'hA3);
        chk({tg, "_avail0"},   64'(ravail), 64'd0);
        chk({tg, "_empty"},    64'(empty),  64'd1);
        tick;
        chk({tg, "_rvalid_drop"}, 64'(rvalid), 64'd0);
    endtask

    initial begin
        int beats;
        int wr_seen;
        int acks;
        int rows_read;

        resetn = 1'b0;
        clr    = 1'b0;
        dv     = 1'b0;
        din    = '0;
        rreq   = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy",    64'(rdy),    64'd1);
        chk("rst_empty",  64'(empty),  64'd1);
        chk("rst_full",   64'(full),   64'd0);
        chk("rst_wpe",    64'(wpe),    64'd0);
        chk("rst_wen",    64'(wen),    64'd0);
        chk("rst_data",   bdata,       64'd0);
        chk("rst_abus",   64'(abus),   64'd0);
        chk("rst_acomp",  64'(acomp),  64'd0);
        chk("rst_avail",  64'(ravail), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_ack",    64'(ack),    64'd0);
        resetn = 1'b1;
        tick;

        // Scenario 1: one row written, committed, read
        run_basic("s1");

        // Scenario 2: fill to full, hold a beat, free one row
        do_clear;
        chk("s2_clr_empty", 64'(empty), 64'd1);
        chk("s2_clr_rdy",   64'(rdy),   64'd1);
        dv = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din = 64'(64'h100 + i);
            tick;
        end
        chk("s2_rdy_full",  64'(rdy),  64'd0);
        chk("s2_full",      64'(full), 64'd1);
        chk("s2_last_wen",  64'(wen),  64'h8);
        chk("s2_last_abus", 64'(abus), 64'd3);
        din = 64'h200;
        tick;
        chk("s2_held_wpe", 64'(wpe),    64'd0);
        chk("s2_held_rdy", 64'(rdy),    64'd0);
        chk("s2_avail4",   64'(ravail), 64'd4);
        rreq = 1'b1;
        #1;
        chk("s2_ack",          64'(ack), 64'd1);
        chk("s2_rdy_same_cyc", 64'(rdy), 64'd0);
        tick;
        rreq = 1'b0;
        chk("s2_rdy_after", 64'(rdy),    64'd1);
        chk("s2_full_after",64'(full),   64'd0);
        chk("s2_rvalid",    64'(rvalid), 64'd1);
        chk("s2_dout0",     dout[0],     64'h100);
        chk("s2_dout3",     dout[3],     64'h103);
        tick;
        dv = 1'b0;
        chk("s2_b17_wpe",  64'(wpe),  64'd1);
        chk("s2_b17_wen",  64'(wen),  64'd1);
        chk("s2_b17_abus", 64'(abus), 64'd0);
        chk("s2_b17_data", bdata,     64'h200);

        // Scenario 3: read request waits for a committed row
        do_clear;
        rreq = 1'b1;
        #1;
        chk("s3_empty_ack", 64'(ack), 64'd0);
        tick;
        chk("s3_rp_hold",   64'(acomp),  64'd0);
        chk("s3_no_rvalid", 64'(rvalid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            dv  = 1'b1;
            din = 64'(64'h300 + i);
            #1;
            chk("s3_ack_early", 64'(ack), 64'd0);
            tick;
        end
        dv = 1'b0;
        #1;
        chk("s3_ack_on_write", 64'(ack), 64'd0);
        tick;
        chk("s3_ack_commit", 64'(ack), 64'd1);
        tick;
        rreq = 1'b0;
        chk("s3_rvalid", 64'(rvalid), 64'd1);
        chk("s3_dout0",  dout[0],     64'h300);
        chk("s3_dout3",  dout[3],     64'h303);

        // Scenario 4: continuous stream, one read request every 4 cycles
        do_clear;
        beats = 0; wr_seen = 0; acks = 0; rows_read = 0;
        for (int cyc = 0; cyc < 400 && rows_read < 40; cyc++) begin
            if (rvalid) begin
                for (int k = 0; k < BC; k++)
                    chk("s4_row_data", dout[k], 64'(64'h4000 + rows_read * 4 + k));
                rows_read++;
            end
            if (wpe) begin
                chk("s4_abus", 64'(abus), 64'((wr_seen / 4) % 4));
                chk("s4_wen",  64'(wen),  64'(1) << (wr_seen % 4));
                chk("s4_data", bdata,     64'(64'h4000 + wr_seen));
                wr_seen++;
            end
            chk("s4_not_full", 64'(full), 64'd0);
            dv   = (beats < 160);
            din  = 64'(64'h4000 + beats);
            rreq = (cyc % 4 == 0);
            #1;
            if (ack) begin
                chk("s4_acomp", 64'(acomp), 64'(acks % 4));
                acks++;
            end
            if (dv && rdy) beats++;
            tick;
        end
        dv   = 1'b0;
        rreq = 1'b0;
        chk("s4_rows_read", 64'(rows_read), 64'd40);
        chk("s4_writes",    64'(wr_seen),   64'd160);

        // Scenario 5: clear right after beat 2 of row 1
        do_clear;
        for (int i = 0; i < 6; i++) begin
            dv  = 1'b1;
            din = 64'(64'hE0 + i);
            tick;
        end
        dv  = 1'b0;
        clr = 1'b1;
        #1;
        chk("s5_pre_empty", 64'(empty), 64'd0);
        tick;
        clr = 1'b0;
        chk("s5_squash_wpe", 64'(wpe),    64'd0);
        chk("s5_squash_wen", 64'(wen),    64'd0);
        chk("s5_empty",      64'(empty),  64'd1);
        chk("s5_avail",      64'(ravail), 64'd0);
        chk("s5_acomp",      64'(acomp),  64'd0);
        chk("s5_rdy",        64'(rdy),    64'd1);
        dv  = 1'b1;
        din = 64'hE6;
        tick;
        dv = 1'b0;
        chk("s5_next_wpe",  64'(wpe),  64'd1);
        chk("s5_next_wen",  64'(wen),  64'd1);
        chk("s5_next_abus", 64'(abus), 64'd0);
        chk("s5_next_data", bdata,     64'hE6);
        tick;

        // Scenario 6: asynchronous reset pulse mid-stream
        for (int i = 0; i < 5; i++) begin
            dv  = 1'b1;
            din = 64'(64'hF0 + i);
            tick;
        end
        #2;
        resetn = 1'b0;
        dv     = 1'b0;
        #1;
        chk("s6_wpe",    64'(wpe),    64'd0);
        chk("s6_wen",    64'(wen),    64'd0);
        chk("s6_data",   bdata,       64'd0);
        chk("s6_abus",   64'(abus),   64'd0);
        chk("s6_rdy",    64'(rdy),    64'd1);
        chk("s6_empty",  64'(empty),  64'd1);
        chk("s6_full",   64'(full),   64'd0);
        chk("s6_avail",  64'(ravail), 64'd0);
        chk("s6_rvalid", 64'(rvalid), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        resetn = 1'b1;
        tick;
        run_basic("s6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
